// File: rtl/if_fetch_ctrl.sv
// ----------------------------------------------------------------------------
// if_fetch_ctrl -- instruction fetch stage: PC register, IF/ID register and
// a small RUN/HOLD/FLUSH FSM reporting what happened at the last edge.
//
// Redirect priority per cycle: irq > branch > jump > stall > sequential.
// A redirect squashes IF/ID to a bubble even while stalled.
// The sequential PC increments bits [30:0] only; bit 31 is the supervisor bit.
//
// Optional feature: define IF_FETCH_IRQ_EN to enable the interrupt redirect
// (taken only while pc[31]=0), epc capture and a one-cycle irq_ack_o pulse.
// Without it irq_i is ignored and irq_ack_o / epc_o read 0.
//
// Ports:
//   clk              clock, rising edge
//   reset            asynchronous active-low reset
//   stall_i          hold PC and IF/ID
//   branch_i/_target taken branch and its target
//   jump_i/_target   jump and its target
//   irq_i            level interrupt request
//   rom_addr_o       ROM address (= PC)
//   rom_data_i       ROM word for rom_addr_o
//   ifid_*_o         IF/ID register (instr, PC+4, valid)
//   state_o          0=RUN 1=HOLD 2=FLUSH
//   irq_ack_o/epc_o  interrupt acknowledge pulse / saved PC
// ----------------------------------------------------------------------------
module if_fetch_ctrl #(
    parameter logic [31:0] RESET_VECTOR = 32'h80000000,
    parameter logic [31:0] IRQ_VECTOR   = 32'h80000004,
    parameter logic [31:0] NOP_INSTR    = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_i,
    input  logic        branch_i,
    input  logic [31:0] branch_target_i,
    input  logic        jump_i,
    input  logic [31:0] jump_target_i,
    input  logic        irq_i,
    output logic [31:0] rom_addr_o,
    input  logic [31:0] rom_data_i,
    output logic [31:0] ifid_instr_o,
    output logic [31:0] ifid_pc4_o,
    output logic        ifid_valid_o,
    output logic [1:0]  state_o,
    output logic        irq_ack_o,
    output logic [31:0] epc_o
);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_HOLD  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_pc4;
    logic        r_valid;
    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;

    logic        w_irq_take;
    logic        w_redirect;
    logic [31:0] w_target;
    logic [31:0] w_pc_seq;

    // Supervisor bit is preserved; the low 31 bits wrap on their own.
    assign w_pc_seq = {r_pc[31], r_pc[30:0] + 31'd4};

`ifdef IF_FETCH_IRQ_EN
    logic        r_ack;
    logic [31:0] r_epc;

    // Interrupts are masked while running in supervisor space.
    assign w_irq_take = irq_i & ~r_pc[31];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ack <= 1'b0;
            r_epc <= 32'h0;
        end else begin
            r_ack <= w_irq_take;
            if (w_irq_take)
                r_epc <= r_pc;
        end
    end

    assign irq_ack_o = r_ack;
    assign epc_o     = r_epc;
`else
    logic w_unused_irq;
    assign w_unused_irq = irq_i;
    assign w_irq_take   = 1'b0;
    assign irq_ack_o    = 1'b0;
    assign epc_o        = 32'h0;
`endif

    assign w_redirect = w_irq_take | branch_i | jump_i;

    always_comb begin
        w_target = jump_target_i;
        if (w_irq_take)
            w_target = IRQ_VECTOR;
        else if (branch_i)
            w_target = branch_target_i;
    end

    // PC and IF/ID datapath
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc    <= RESET_VECTOR;
            r_instr <= NOP_INSTR;
            r_pc4   <= 32'h0;
            r_valid <= 1'b0;
        end else if (w_redirect) begin
            r_pc    <= w_target;
            r_instr <= NOP_INSTR;
            r_pc4   <= 32'h0;
            r_valid <= 1'b0;
        end else if (!stall_i) begin
            r_pc    <= w_pc_seq;
            r_instr <= rom_data_i;
            r_pc4   <= w_pc_seq;
            r_valid <= 1'b1;
        end
    end

    // FSM: state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_state <= ST_RUN;
        else
            r_state <= w_state_nxt;
    end

    // FSM: next state depends only on this cycle's action, so an illegal
    // encoding is left after a single edge.
    always_comb begin
        w_state_nxt = ST_RUN;
        if (w_redirect)
            w_state_nxt = ST_FLUSH;
        else if (stall_i)
            w_state_nxt = ST_HOLD;
    end

    // FSM: outputs; an illegal encoding reads as RUN.
    always_comb begin
        case (r_state)
            ST_HOLD:  state_o = ST_HOLD;
            ST_FLUSH: state_o = ST_FLUSH;
            default:  state_o = ST_RUN;
        endcase
    end

    assign rom_addr_o   = r_pc;
    assign ifid_instr_o = r_instr;
    assign ifid_pc4_o   = r_pc4;
    assign ifid_valid_o = r_valid;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
module tb_if_fetch_ctrl;

    logic        clk;
    logic        reset;
    logic        stall_i;
    logic        branch_i;
    logic [31:0] branch_target_i;
    logic        jump_i;
    logic [31:0] jump_target_i;
    logic        irq_i;
    logic [31:0] rom_addr_o;
    logic [31:0] rom_data_i;
    logic [31:0] ifid_instr_o;
    logic [31:0] ifid_pc4_o;
    logic        ifid_valid_o;
    logic [1:0]  state_o;
    logic        irq_ack_o;
    logic [31:0] epc_o;

    int n_tests = 0;
    int n_fail  = 0;

    if_fetch_ctrl dut (
        .clk(clk), .reset(reset), .stall_i(stall_i),
        .branch_i(branch_i), .branch_target_i(branch_target_i),
        .jump_i(jump_i), .jump_target_i(jump_target_i),
        .irq_i(irq_i), .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i),
        .ifid_instr_o(ifid_instr_o), .ifid_pc4_o(ifid_pc4_o),
        .ifid_valid_o(ifid_valid_o), .state_o(state_o),
        .irq_ack_o(irq_ack_o), .epc_o(epc_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic br, input logic [31:0] bt,
                         input logic jp, input logic [31:0] jt, input logic irq,
                         input logic [31:0] rom);
        stall_i = st; branch_i = br; branch_target_i = bt;
        jump_i = jp; jump_target_i = jt; irq_i = irq; rom_data_i = rom;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        st, br, jp;
        logic [31:0] bt, jt, rom;
        logic [31:0] e_addr, e_instr, e_pc4;
        logic        e_vld;
        logic [1:0]  e_st;
    } vec_t;

    vec_t tv[15];

    // Reference model, expressed directly from the fetch rules
    logic [31:0] m_pc, m_instr, m_pc4, m_epc;
    logic        m_vld, m_ack;
    logic [1:0]  m_st;

    task automatic model_reset;
        m_pc = 32'h80000000; m_instr = 32'h0; m_pc4 = 32'h0; m_vld = 1'b0;
        m_st = 2'd0; m_ack = 1'b0; m_epc = 32'h0;
    endtask

    task automatic model_step(input logic st, input logic br, input logic [31:0] bt,
                              input logic jp, input logic [31:0] jt, input logic irq,
                              input logic [31:0] rom);
        logic take_irq;
        logic [31:0] nxt;
`ifdef IF_FETCH_IRQ_EN
        take_irq = irq && (m_pc < 32'h80000000);
`else
        take_irq = 1'b0;
`endif
        nxt = (m_pc & 32'h80000000) | ((m_pc + 32'd4) & 32'h7FFFFFFF);
        if (take_irq || br || jp) begin
            if (take_irq) m_epc = m_pc;
            m_pc = take_irq ? 32'h80000004 : (br ? bt : jt);
            m_instr = 32'h0; m_pc4 = 32'h0; m_vld = 1'b0; m_st = 2'd2;
        end else if (st) begin
            m_st = 2'd1;
        end else begin
            m_pc = nxt; m_instr = rom; m_pc4 = nxt; m_vld = 1'b1; m_st = 2'd0;
        end
        m_ack = take_irq;
    endtask

    task automatic model_check(input int i);
        string s;
        s = $sformatf("rnd%0d", i);
        chk({s, ".addr"},  rom_addr_o, m_pc);
        chk({s, ".instr"}, ifid_instr_o, m_instr);
        chk({s, ".pc4"},   ifid_pc4_o, m_pc4);
        chk({s, ".valid"}, {31'b0, ifid_valid_o}, {31'b0, m_vld});
        chk({s, ".state"}, {30'b0, state_o}, {30'b0, m_st});
        chk({s, ".ack"},   {31'b0, irq_ack_o}, {31'b0, m_ack});
        chk({s, ".epc"},   epc_o, m_epc);
    endtask

    initial begin
        //         st    br    jp    bt            jt            rom           addr          instr         pc4           v     st
        tv[0]  = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h20043039, 32'h80000004, 32'h20043039, 32'h80000004, 1'b1, 2'd0};
        tv[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h11111111, 32'h80000008, 32'h11111111, 32'h80000008, 1'b1, 2'd0};
        tv[2]  = '{1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        32'h22222222, 32'h80000008, 32'h11111111, 32'h80000008, 1'b1, 2'd1};
        tv[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        32'h22222223, 32'h80000008, 32'h11111111, 32'h80000008, 1'b1, 2'd1};
        tv[4]  = '{1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        32'h22222224, 32'h80000008, 32'h11111111, 32'h80000008, 1'b1, 2'd1};
        tv[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h33333333, 32'h8000000C, 32'h33333333, 32'h8000000C, 1'b1, 2'd0};
        tv[6]  = '{1'b1, 1'b1, 1'b0, 32'h80000018, 32'h0,        32'h99999999, 32'h80000018, 32'h0,        32'h0,        1'b0, 2'd2};
        tv[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h44444444, 32'h8000001C, 32'h44444444, 32'h8000001C, 1'b1, 2'd0};
        tv[8]  = '{1'b0, 1'b1, 1'b1, 32'h80000040, 32'h8000002C, 32'h99999999, 32'h80000040, 32'h0,        32'h0,        1'b0, 2'd2};
        tv[9]  = '{1'b0, 1'b0, 1'b1, 32'h0,        32'h00000003, 32'h99999999, 32'h00000003, 32'h0,        32'h0,        1'b0, 2'd2};
        tv[10] = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h55555555, 32'h00000007, 32'h55555555, 32'h00000007, 1'b1, 2'd0};
        tv[11] = '{1'b0, 1'b0, 1'b1, 32'h0,        32'h7FFFFFFC, 32'h99999999, 32'h7FFFFFFC, 32'h0,        32'h0,        1'b0, 2'd2};
        tv[12] = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h66666666, 32'h00000000, 32'h66666666, 32'h00000000, 1'b1, 2'd0};
        tv[13] = '{1'b1, 1'b0, 1'b1, 32'h0,        32'hFFFFFFFC, 32'h99999999, 32'hFFFFFFFC, 32'h0,        32'h0,        1'b0, 2'd2};
        tv[14] = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h77777777, 32'h80000000, 32'h77777777, 32'h80000000, 1'b1, 2'd0};

        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        reset = 1'b1;
        #1 reset = 1'b0;
        #1;
        chk("rst.addr",  rom_addr_o, 32'h80000000);
        chk("rst.instr", ifid_instr_o, 32'h0);
        chk("rst.pc4",   ifid_pc4_o, 32'h0);
        chk("rst.valid", {31'b0, ifid_valid_o}, 32'h0);
        chk("rst.state", {30'b0, state_o}, 32'h0);
        chk("rst.ack",   {31'b0, irq_ack_o}, 32'h0);
        chk("rst.epc",   epc_o, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // Table-driven directed vectors
        for (int i = 0; i < 15; i++) begin
            drive(tv[i].st, tv[i].br, tv[i].bt, tv[i].jp, tv[i].jt, 1'b0, tv[i].rom);
            tick();
            chk($sformatf("tv%0d.addr", i),  rom_addr_o, tv[i].e_addr);
            chk($sformatf("tv%0d.instr", i), ifid_instr_o, tv[i].e_instr);
            chk($sformatf("tv%0d.pc4", i),   ifid_pc4_o, tv[i].e_pc4);
            chk($sformatf("tv%0d.valid", i), {31'b0, ifid_valid_o}, {31'b0, tv[i].e_vld});
            chk($sformatf("tv%0d.state", i), {30'b0, state_o}, {30'b0, tv[i].e_st});
        end

        // Reset asserted mid-stall at PC 0x80000020
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h80000020, 1'b0, 32'h0);
        tick();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'hABCD0000);
        tick();
        chk("stall.addr",  rom_addr_o, 32'h80000020);
        chk("stall.state", {30'b0, state_o}, 32'h1);
        #1 reset = 1'b0;
        #1;
        chk("midrst.addr",  rom_addr_o, 32'h80000000);
        chk("midrst.valid", {31'b0, ifid_valid_o}, 32'h0);
        chk("midrst.state", {30'b0, state_o}, 32'h0);
        chk("midrst.instr", ifid_instr_o, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h12345678);
        tick();
        chk("postrst.addr",  rom_addr_o, 32'h80000004);
        chk("postrst.instr", ifid_instr_o, 32'h12345678);
        chk("postrst.pc4",   ifid_pc4_o, 32'h80000004);
        chk("postrst.valid", {31'b0, ifid_valid_o}, 32'h1);

        // Interrupt at user PC, then held while in supervisor space
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h00000010, 1'b0, 32'h0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'hCAFE0001);
        tick();
`ifdef IF_FETCH_IRQ_EN
        chk("irq.addr",  rom_addr_o, 32'h80000004);
        chk("irq.epc",   epc_o, 32'h00000010);
        chk("irq.ack",   {31'b0, irq_ack_o}, 32'h1);
        chk("irq.valid", {31'b0, ifid_valid_o}, 32'h0);
        tick();
        chk("irqsup.addr", rom_addr_o, 32'h80000008);
        chk("irqsup.ack",  {31'b0, irq_ack_o}, 32'h0);
        chk("irqsup.epc",  epc_o, 32'h00000010);
`else
        chk("noirq.addr",  rom_addr_o, 32'h00000014);
        chk("noirq.ack",   {31'b0, irq_ack_o}, 32'h0);
        chk("noirq.epc",   epc_o, 32'h0);
        chk("noirq.instr", ifid_instr_o, 32'hCAFE0001);
`endif

        // Randomized run against the reference model
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        for (int i = 0; i < 400; i++) begin
            logic st, br, jp, irq;
            logic [31:0] bt, jt, rom;
            st  = ($urandom_range(0, 99) < 30);
            br  = ($urandom_range(0, 99) < 10);
            jp  = ($urandom_range(0, 99) < 10);
            irq = ($urandom_range(0, 99) < 15);
            bt  = $urandom();
            jt  = $urandom();
            rom = $urandom();
            drive(st, br, bt, jp, jt, irq, rom);
            model_step(st, br, bt, jp, jt, irq, rom);
            tick();
            model_check(i);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
